// File: rtl/irq_request_latch_pkg.sv
// Shared widths and FSM encodings for the interrupt request capture stage.
package irq_request_latch_pkg;

    localparam int unsigned IRQ_NCH = 4;
    localparam int unsigned IRQ_IDW = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_request_latch_sync_edge_det.sv
// One-channel synchroniser plus rising-edge detector; emits a registered one-cycle pulse.
module irq_request_latch_sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   edge_q;
    logic                   s_c;

    assign s_c = sync_q[SYNC_STAGES-1];

    // Pulse is registered so pending updates SYNC_STAGES+1 edges after first sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
            s_d_q  <= s_c;
            edge_q <= s_c & ~s_d_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/irq_request_latch.sv
// Sticky request capture with masked pending vector and holdoff-gated irq line.
// Optional per-channel overflow flags built when IRQ_OVERFLOW_EN is defined.
module irq_request_latch
    import irq_request_latch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IRQ_NCH-1:0] req_i,
    input  logic [IRQ_NCH-1:0] mask_i,
    input  logic               ack_i,
    input  logic [IRQ_IDW-1:0] ack_id_i,
    output logic [IRQ_NCH-1:0] pend_o,
    output logic               irq_o,
    output logic [IRQ_NCH-1:0] ovf_o
);

    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLDOFF_CYC == 0) ? '0 : CNT_W'(HOLDOFF_CYC - 1);

    logic [IRQ_NCH-1:0] edge_c;
    logic [IRQ_NCH-1:0] ack_dec_c;
    logic [IRQ_NCH-1:0] pend_d, pend_q;
    irq_state_e         state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               irq_q;

    for (genvar n = 0; n < IRQ_NCH; n++) begin : g_ch
        irq_request_latch_sync_edge_det #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sed (
            .clk    (clk),
            .rst_n  (rst_n),
            .req_i  (req_i[n]),
            .edge_o (edge_c[n])
        );
    end

    always_comb begin
        ack_dec_c = '0;
        if (ack_i) ack_dec_c[ack_id_i] = 1'b1;
    end

    // A new edge wins over a same-cycle acknowledge of that channel.
    assign pend_d = edge_c | (pend_q & ~ack_dec_c);
    assign pend_o = pend_q & ~mask_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pend_o) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (ack_i) begin
                    if (HOLDOFF_CYC == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (pend_o == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= (state_d == ST_ACTIVE);
        end
    end

    assign irq_o = irq_q;

`ifdef IRQ_OVERFLOW_EN
    logic [IRQ_NCH-1:0] ovf_d, ovf_q;

    // Overflow uses the raw pending bits; the mask does not hide a lost edge.
    assign ovf_d = (edge_c & pend_q) | (ovf_q & ~ack_dec_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = '0;
`endif

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed scoreboard bench for irq_request_latch (default parameters).
module tb_irq_request_latch;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_i;
    logic [3:0] mask_i;
    logic       ack_i;
    logic [1:0] ack_id_i;
    logic [3:0] pend_o;
    logic       irq_o;
    logic [3:0] ovf_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] pend;
        logic       irq;
        logic [3:0] ovf;
    } exp_t;

    exp_t sb[$];

    localparam logic [3:0] OVF0 =
`ifdef IRQ_OVERFLOW_EN
        4'b0001;
`else
        4'b0000;
`endif

    irq_request_latch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .mask_i   (mask_i),
        .ack_i    (ack_i),
        .ack_id_i (ack_id_i),
        .pend_o   (pend_o),
        .irq_o    (irq_o),
        .ovf_o    (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] p, input logic i,
                              input logic [3:0] o);
        exp_t e;
        e.tag  = tag;
        e.pend = p;
        e.irq  = i;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 entries expected at least 1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (pend_o === e.pend) else begin
            errors++;
            $error("FAIL %s pend_o got %b expected %b", e.tag, pend_o, e.pend);
        end
        checks++;
        assert (irq_o === e.irq) else begin
            errors++;
            $error("FAIL %s irq_o got %b expected %b", e.tag, irq_o, e.irq);
        end
        checks++;
        assert (ovf_o === e.ovf) else begin
            errors++;
            $error("FAIL %s ovf_o got %b expected %b", e.tag, ovf_o, e.ovf);
        end
    endtask

    task automatic ack(input logic [1:0] id);
        ack_i    = 1'b1;
        ack_id_i = id;
        tick(1);
        ack_i    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        req_i    = 4'b0100;
        mask_i   = 4'b0000;
        ack_i    = 1'b0;
        ack_id_i = 2'd0;

        // Reset with ch2 already high.
        expect_out("reset", 4'b0000, 1'b0, 4'b0000);
        tick(2);
        check();
        rst_n = 1'b1;
        expect_out("cap_early", 4'b0000, 1'b0, 4'b0000);
        tick(3);
        check();
        expect_out("cap_lat", 4'b0100, 1'b0, 4'b0000);
        tick(1);
        check();
        expect_out("cap_irq", 4'b0100, 1'b1, 4'b0000);
        tick(1);
        check();

        // Reset mid-operation drops everything.
        rst_n = 1'b0;
        expect_out("rst_mid", 4'b0000, 1'b0, 4'b0000);
        #1;
        check();
        req_i = 4'b0000;
        tick(1);
        rst_n = 1'b1;
        expect_out("rst_gone", 4'b0000, 1'b0, 4'b0000);
        tick(5);
        check();

        // Ack of a non-pending channel in IDLE.
        expect_out("ack_idle", 4'b0000, 1'b0, 4'b0000);
        ack(2'd3);
        check();

        // Single request, ack, holdoff with nothing left.
        req_i = 4'b0010;
        expect_out("ch1_pend", 4'b0010, 1'b0, 4'b0000);
        tick(4);
        check();
        expect_out("ch1_irq", 4'b0010, 1'b1, 4'b0000);
        tick(1);
        check();
        tick(3);
        expect_out("ch1_ack", 4'b0000, 1'b0, 4'b0000);
        ack(2'd1);
        check();
        req_i = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            expect_out("ch1_low", 4'b0000, 1'b0, 4'b0000);
            tick(1);
            check();
        end

        // Two requests; ack highest, remaining reasserts after holdoff.
        req_i = 4'b1001;
        expect_out("dual_pend", 4'b1001, 1'b0, 4'b0000);
        tick(4);
        check();
        expect_out("dual_irq", 4'b1001, 1'b1, 4'b0000);
        tick(1);
        check();
        expect_out("ack3", 4'b0001, 1'b0, 4'b0000);
        ack(2'd3);
        check();
        for (int i = 0; i < 4; i++) begin
            expect_out("holdoff", 4'b0001, 1'b0, 4'b0000);
            tick(1);
            check();
        end
        expect_out("reassert", 4'b0001, 1'b1, 4'b0000);
        tick(1);
        check();
        expect_out("ack0", 4'b0000, 1'b0, 4'b0000);
        ack(2'd0);
        check();
        req_i = 4'b0000;
        tick(6);

        // Masked capture exposed the same cycle the mask clears.
        mask_i = 4'b0010;
        req_i  = 4'b0010;
        expect_out("masked", 4'b0000, 1'b0, 4'b0000);
        tick(4);
        check();
        expect_out("masked_hold", 4'b0000, 1'b0, 4'b0000);
        tick(2);
        check();
        mask_i = 4'b0000;
        expect_out("unmask", 4'b0010, 1'b0, 4'b0000);
        #1;
        check();
        expect_out("unmask_irq", 4'b0010, 1'b1, 4'b0000);
        tick(1);
        check();
        expect_out("unmask_ack", 4'b0000, 1'b0, 4'b0000);
        ack(2'd1);
        check();
        req_i = 4'b0000;
        tick(6);

        // New edge on ch2 coincides with ack of ch2: set wins.
        req_i = 4'b0100;
        tick(3);
        expect_out("set_wins", 4'b0100, 1'b0, 4'b0000);
        ack(2'd2);
        check();
        expect_out("set_wins_irq", 4'b0100, 1'b1, 4'b0000);
        tick(1);
        check();
        expect_out("ch2_ack", 4'b0000, 1'b0, 4'b0000);
        ack(2'd2);
        check();
        req_i = 4'b0000;
        tick(6);

        // Second ch0 edge before ack.
        req_i = 4'b0001;
        expect_out("ovf_first", 4'b0001, 1'b0, 4'b0000);
        tick(4);
        check();
        req_i = 4'b0000;
        tick(2);
        req_i = 4'b0001;
        expect_out("ovf_set", 4'b0001, 1'b1, OVF0);
        tick(4);
        check();
        expect_out("ovf_clr", 4'b0000, 1'b0, 4'b0000);
        ack(2'd0);
        check();
        req_i = 4'b0000;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
